// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one pipelined memory port between an I-cache and a
//                D-cache. Serves 8-word block fills (I or D) and single-word
//                D-cache write-throughs. Priority on each idle cycle is
//                D write > D fill > I fill.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n               clock, asynchronous active-low reset
//    icache_MemRead/_mem_addr I-cache fill request and miss address
//    dcache_MemRead/MemWrite  D-cache fill / write-through requests
//    dcache_mem_addr/_write_data  D-cache address and write data
//    mem_data_valid/_out      memory read return (fixed 4-cycle latency)
//    mem_enable/_wr/_addr/_data_in  memory command port
//    *_MemDataValid           fill word valid, routed to the owning cache
//    mem_read_data            fill word (straight from memory)
//    *_fill_done              pulse with the 8th fill word
//    dcache_write_done        pulse in the cycle the write is issued
//    *_grant                  owner indication for the duration of a fill
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_MemRead,
  input  logic [15:0] icache_mem_addr,
  input  logic        dcache_MemRead,
  input  logic        dcache_MemWrite,
  input  logic [15:0] dcache_mem_addr,
  input  logic [15:0] dcache_mem_write_data,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_out,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        icache_MemDataValid,
  output logic        dcache_MemDataValid,
  output logic [15:0] mem_read_data,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        dcache_write_done,
  output logic        icache_grant,
  output logic        dcache_grant
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  localparam logic       OWN_I     = 1'b0;
  localparam logic       OWN_D     = 1'b1;

  localparam logic [3:0] FILL_BEATS = 4'd8;
  localparam logic [3:0] LAST_WORD  = 4'd7;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [11:0] base_q,  base_d;
  logic [3:0]  issue_q, issue_d;
  logic [3:0]  recv_q,  recv_d;

  logic        w_last_word;
  logic        w_unused_iaddr_lo;

  // Fill addresses are block aligned, so the I-cache offset bits never matter.
  assign w_unused_iaddr_lo = ^icache_mem_addr[3:0];

  // Memory returns are only meaningful while a fill is outstanding; anything
  // arriving in IDLE/WRITE (e.g. leftovers from before a reset) is dropped.
  assign w_last_word = (state_q == ST_FILL) && mem_data_valid && (recv_q == LAST_WORD);

  assign mem_read_data = mem_data_out;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      base_q  <= 12'h000;
      issue_q <= 4'd0;
      recv_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    case (state_q)
      ST_IDLE: begin
        issue_d = 4'd0;
        recv_d  = 4'd0;
        if (dcache_MemWrite) begin
          state_d = ST_WRITE;
        end else if (dcache_MemRead) begin
          state_d = ST_FILL;
          owner_d = OWN_D;
          base_d  = dcache_mem_addr[15:4];
        end else if (icache_MemRead) begin
          state_d = ST_FILL;
          owner_d = OWN_I;
          base_d  = icache_mem_addr[15:4];
        end
      end
      ST_FILL: begin
        // Issue side saturates at 8 beats; receive side ends the fill.
        if (issue_q != FILL_BEATS) begin
          issue_d = issue_q + 4'd1;
        end
        if (mem_data_valid) begin
          if (recv_q == LAST_WORD) begin
            state_d = ST_IDLE;
            issue_d = 4'd0;
            recv_d  = 4'd0;
          end else begin
            recv_d = recv_q + 4'd1;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_enable          = 1'b0;
    mem_wr              = 1'b0;
    mem_addr            = 16'h0000;
    mem_data_in         = 16'h0000;
    icache_MemDataValid = 1'b0;
    dcache_MemDataValid = 1'b0;
    icache_fill_done    = 1'b0;
    dcache_fill_done    = 1'b0;
    dcache_write_done   = 1'b0;
    icache_grant        = 1'b0;
    dcache_grant        = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (issue_q != FILL_BEATS) begin
          mem_enable = 1'b1;
          mem_addr   = {base_q, issue_q[2:0], 1'b0};
        end
        if (owner_q == OWN_D) begin
          dcache_MemDataValid = mem_data_valid;
          dcache_fill_done    = w_last_word;
          dcache_grant        = 1'b1;
        end else begin
          icache_MemDataValid = mem_data_valid;
          icache_fill_done    = w_last_word;
          icache_grant        = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_enable        = 1'b1;
        mem_wr            = 1'b1;
        mem_addr          = dcache_mem_addr;
        mem_data_in       = dcache_mem_write_data;
        dcache_write_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Expected memory commands
//                and fill words are queued when requests are raised; a
//                monitor pops and compares whenever the DUT issues a beat or
//                presents a fill word. Includes a 4-cycle pipelined memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_MemRead = 1'b0;
  logic [15:0] icache_mem_addr = 16'h0;
  logic        dcache_MemRead = 1'b0;
  logic        dcache_MemWrite = 1'b0;
  logic [15:0] dcache_mem_addr = 16'h0;
  logic [15:0] dcache_mem_write_data = 16'h0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data_out = 16'h0;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_read_data;
  logic        icache_MemDataValid, dcache_MemDataValid;
  logic        icache_fill_done, dcache_fill_done, dcache_write_done;
  logic        icache_grant, dcache_grant;

  mem_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .icache_MemRead        (icache_MemRead),
    .icache_mem_addr       (icache_mem_addr),
    .dcache_MemRead        (dcache_MemRead),
    .dcache_MemWrite       (dcache_MemWrite),
    .dcache_mem_addr       (dcache_mem_addr),
    .dcache_mem_write_data (dcache_mem_write_data),
    .mem_data_valid        (mem_data_valid),
    .mem_data_out          (mem_data_out),
    .mem_enable            (mem_enable),
    .mem_wr                (mem_wr),
    .mem_addr              (mem_addr),
    .mem_data_in           (mem_data_in),
    .icache_MemDataValid   (icache_MemDataValid),
    .dcache_MemDataValid   (dcache_MemDataValid),
    .mem_read_data         (mem_read_data),
    .icache_fill_done      (icache_fill_done),
    .dcache_fill_done      (dcache_fill_done),
    .dcache_write_done     (dcache_write_done),
    .icache_grant          (icache_grant),
    .dcache_grant          (dcache_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          first;
    bit          client;   // 0 = I-cache, 1 = D-cache
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    bit          client;
    bit          last;
    logic [15:0] data;
  } val_t;

  beat_t exp_mem[$];
  val_t  exp_val[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_end = -100;
  int grant_own = 0;       // 0 none, 1 I-cache, 2 D-cache
  int v_seen   = 0;
  bit i_done_f = 1'b0;
  bit d_done_f = 1'b0;
  bit w_done_f = 1'b0;
  logic [15:0] salt = 16'h0;

  bit          p_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] p_d [3] = '{16'h0, 16'h0, 16'h0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Memory contents: salt 0 gives the words 1..8 across a block.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (salt == 16'h0) return {13'd0, a[3:1]} + 16'd1;
    return salt ^ a ^ 16'h5A3C;
  endfunction

  function automatic void push_fill(input bit client, input logic [15:0] a);
    beat_t b;
    val_t  v;
    logic [15:0] ba;
    for (int k = 0; k < 8; k++) begin
      ba = {a[15:4], k[2:0], 1'b0};
      b.wr = 1'b0; b.first = (k == 0); b.client = client; b.addr = ba; b.data = 16'h0;
      exp_mem.push_back(b);
      v.client = client; v.last = (k == 7); v.data = mem_word(ba);
      exp_val.push_back(v);
    end
  endfunction

  function automatic void push_write(input logic [15:0] a, input logic [15:0] d);
    beat_t b;
    b.wr = 1'b1; b.first = 1'b1; b.client = 1'b1; b.addr = a; b.data = d;
    exp_mem.push_back(b);
  endfunction

  // Pipelined memory: a read issued in cycle c returns in cycle c+3.
  initial begin
    forever begin
      @(negedge clk);
      mem_data_valid = p_v[2];
      mem_data_out   = p_v[2] ? p_d[2] : 16'($urandom);
      p_v[2] = p_v[1]; p_d[2] = p_d[1];
      p_v[1] = p_v[0]; p_d[1] = p_d[0];
      p_v[0] = mem_enable && !mem_wr;
      p_d[0] = mem_word(mem_addr);
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t b;
    val_t  v;
    bit    clr;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      clr = 1'b0;
      check("read_data_follow", 64'(mem_read_data), 64'(mem_data_out));
      if (!rst_n) begin
        check("reset_outputs",
              64'({mem_enable, mem_wr, mem_addr, mem_data_in, icache_MemDataValid,
                   dcache_MemDataValid, icache_fill_done, dcache_fill_done,
                   dcache_write_done, icache_grant, dcache_grant}), 64'(0));
        grant_own = 0;
      end else begin
        if (mem_enable) begin
          if (exp_mem.size() == 0) begin
            fail_now("unexpected_beat", 64'({mem_wr, mem_addr}));
          end else begin
            b = exp_mem.pop_front();
            check("beat", 64'({mem_wr, mem_addr, (mem_wr ? mem_data_in : 16'h0), dcache_write_done}),
                  64'({b.wr, b.addr, (b.wr ? b.data : 16'h0), b.wr}));
            if (b.first) begin
              check("idle_gap", 64'((cyc - last_end) >= 2), 64'(1));
              if (!b.wr) grant_own = b.client ? 2 : 1;
            end
            if (b.wr) begin
              last_end = cyc;
              w_done_f = 1'b1;
            end
          end
        end else begin
          check("no_write_done", 64'(dcache_write_done), 64'(0));
        end
        if (icache_MemDataValid || dcache_MemDataValid) begin
          if (exp_val.size() == 0) begin
            fail_now("unexpected_valid", 64'({icache_MemDataValid, dcache_MemDataValid, mem_read_data}));
          end else begin
            v = exp_val.pop_front();
            check("fill_word",
                  64'({icache_MemDataValid, dcache_MemDataValid, mem_read_data,
                       icache_fill_done, dcache_fill_done}),
                  64'({!v.client, v.client, v.data, v.last && !v.client, v.last && v.client}));
            v_seen++;
            if (v.last) begin
              if (v.client) d_done_f = 1'b1;
              else          i_done_f = 1'b1;
              last_end = cyc;
              clr = 1'b1;
            end
          end
        end else begin
          check("no_fill_done", 64'({icache_fill_done, dcache_fill_done}), 64'(0));
        end
        check("grant", 64'({icache_grant, dcache_grant}),
              64'({grant_own == 1, grant_own == 2}));
        if (clr) grant_own = 0;
      end
    end
  end

  // One burst of simultaneous requests; each requester holds until done.
  // late_w > 0 raises the write that many cycles later (I/D fill already running).
  task automatic episode(input bit w, input bit d, input bit i,
                         input logic [15:0] wa, input logic [15:0] wd,
                         input logic [15:0] da, input logic [15:0] ia,
                         input bit early, input int late_w);
    if (w && late_w == 0) push_write(wa, wd);
    if (d) push_fill(1'b1, da);
    if (i) push_fill(1'b0, ia);
    if (w && late_w > 0) push_write(wa, wd);
    @(negedge clk);
    i_done_f = 1'b0; d_done_f = 1'b0; w_done_f = 1'b0; v_seen = 0;
    dcache_MemWrite       = w && (late_w == 0);
    dcache_mem_addr       = (w && late_w == 0) ? wa : da;
    dcache_mem_write_data = wd;
    dcache_MemRead        = d;
    icache_MemRead        = i;
    icache_mem_addr       = ia;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (w_done_f) begin
        dcache_MemWrite = 1'b0;
        dcache_mem_addr = da;
      end
      if (d_done_f) dcache_MemRead = 1'b0;
      if (i_done_f) icache_MemRead = 1'b0;
      if (early && c == 0) begin
        icache_MemRead = 1'b0;
        dcache_MemRead = 1'b0;
      end
      if (w && late_w > 0 && c == late_w) begin
        dcache_MemWrite = 1'b1;
        dcache_mem_addr = wa;
      end
      if ((!w || w_done_f) && (!d || d_done_f) && (!i || i_done_f)) break;
      if (c == 399) fail_now("episode_timeout", 64'({w_done_f, d_done_f, i_done_f}));
    end
    repeat (3) @(negedge clk);
    check("queues_drained", 64'(exp_mem.size() + exp_val.size()), 64'(0));
    exp_mem.delete();
    exp_val.delete();
  endtask

  initial begin
    bit w, d, i, early;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // I-fill with counting memory data 1..8
    salt = 16'h0;
    episode(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0024, 1'b0, 0);
    // D and I contend: D first
    salt = 16'h1357;
    episode(1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0200, 16'h0100, 1'b0, 0);
    // Write beats I fill
    salt = 16'h2468;
    episode(1'b1, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0, 16'h0500, 1'b0, 0);
    // Early deassert of I request
    salt = 16'h0;
    episode(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0A60, 1'b1, 0);
    // Write arriving mid-fill waits for the fill
    salt = 16'h3C3C;
    episode(1'b1, 1'b0, 1'b1, 16'h0F02, 16'h1234, 16'h0, 16'h0780, 1'b0, 3);
    // Write and D fill together share the D address bus
    salt = 16'h0F0F;
    episode(1'b1, 1'b1, 1'b0, 16'h0122, 16'hCAFE, 16'h0840, 16'h0, 1'b0, 0);

    // Reset after the 3rd fill word; stale returns must be ignored
    salt = 16'h4444;
    push_fill(1'b0, 16'h0420);
    @(negedge clk);
    v_seen = 0; i_done_f = 1'b0;
    icache_MemRead = 1'b1; icache_mem_addr = 16'h0420;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (v_seen >= 3) break;
      if (c == 99) fail_now("reset_wait_timeout", 64'(v_seen));
    end
    rst_n = 1'b0;
    icache_MemRead = 1'b0;
    exp_mem.delete();
    exp_val.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    salt = 16'h5555;
    episode(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0300, 1'b0, 0);

    // Randomised bursts
    for (int n = 0; n < 25; n++) begin
      w = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      i = 1'($urandom_range(0, 1));
      if (!w && !d && !i) i = 1'b1;
      early = (!w && (d ^ i)) ? 1'($urandom_range(0, 1)) : 1'b0;
      salt = 16'($urandom_range(1, 65535));
      episode(w, d, i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), early, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 icache_MemRead  in  1  I-cache requests a block fill.
REQ-005 icache_mem_addr  in  16  I-cache miss byte address.
REQ-006 dcache_MemRead  in  1  D-cache requests a block fill.
REQ-007 dcache_MemWrite  in  1  D-cache requests a single-word write-through.
REQ-008 dcache_mem_addr  in  16  D-cache read/write byte address.
REQ-009 dcache_mem_write_data  in  16  D-cache write data.
REQ-010 mem_data_valid  in  1  memory read data valid; fixed 4-cycle pipelined latency.
REQ-011 mem_data_out  in  16  memory read data.
REQ-012 mem_enable  out  1  memory access this cycle.
REQ-013 mem_wr  out  1  1=write, 0=read; meaningful only with mem_enable.
REQ-014 mem_addr  out  16  memory byte address.
REQ-015 mem_data_in  out  16  memory write data.
REQ-016 icache_MemDataValid / dcache_MemDataValid  out  1 each  fill word valid to that cache.
REQ-017 mem_read_data  out  16  fill word, shared by both caches; equals mem_data_out.
REQ-018 icache_fill_done / dcache_fill_done  out  1 each  one-cycle pulse with 8th fill word.
REQ-019 dcache_write_done  out  1  one-cycle pulse when write issued.
REQ-020 icache_grant / dcache_grant  out  1 each  client owns memory (fill in progress).

Function
REQ-021 States SHALL be IDLE, FILL, WRITE; owner register (I or D) valid in FILL.
REQ-022 In IDLE, priority SHALL be dcache_MemWrite > dcache_MemRead > icache_MemRead; selection sampled at the clock edge.
REQ-023 On fill accept: latch base = addr[15:4] and owner, state -> FILL next cycle.
REQ-024 FILL issue: 3-bit issue counter k = 0..7, one beat per cycle, starting in first FILL cycle: mem_enable=1, mem_wr=0, mem_addr = {base, k, 1'b0}; after 8 beats mem_enable=0.
REQ-025 FILL receive: 4-bit receive counter incremented on each mem_data_valid; <owner>_MemDataValid = mem_data_valid while in FILL; other client's valid SHALL be 0.
REQ-026 <owner>_fill_done SHALL assert with the 8th valid word; state -> IDLE next edge; counters clear.
REQ-027 Request deassert mid-fill SHALL NOT abort; all 8 words still forwarded.
REQ-028 mem_data_valid in IDLE or WRITE SHALL be ignored (no cache valid, no counter change).
REQ-029 WRITE lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=dcache_mem_addr, mem_data_in=dcache_mem_write_data, dcache_write_done=1; then IDLE.
REQ-030 Requests arriving during FILL/WRITE SHALL wait (held by requester) and be arbitrated in next IDLE cycle; minimum one IDLE cycle between operations.
REQ-031 Grant output SHALL be 1 for the owner throughout FILL only.
REQ-032 Counters SHALL NOT wrap within a fill; issue counter stops at 8 beats.

Reset
REQ-033 On rst_n low (any time, incl. mid-fill): state IDLE, counters 0, owner I, all outputs 0 except mem_read_data (follows mem_data_out); in-flight memory returns after reset SHALL be discarded per REQ-028.

Verification
REQ-034 I-fill: icache_MemRead=1, addr 0x0024 -> beats 0x0020..0x002E over 8 cycles; memory returns 1..8 from cycle 4 of fill -> icache_MemDataValid x8 with 1..8, icache_fill_done on 8.
REQ-035 Contention: icache_MemRead and dcache_MemRead same cycle, addrs 0x0100/0x0200 -> D fill (0x0200..0x020E) first, I fill (0x0100..) starts after one IDLE cycle; no cross-valids.
REQ-036 Write priority: dcache_MemWrite addr 0x0040 data 0xBEEF with icache_MemRead -> one WRITE cycle (mem_wr=1, 0x0040, 0xBEEF, dcache_write_done), then I fill.
REQ-037 Reset mid-fill: rst_n low after 3rd valid word -> outputs 0 immediately; remaining returns produce no valids; new fill to 0x0300 completes all 8 words.
REQ-038 Early deassert: icache_MemRead dropped after 1 cycle -> full 8-beat fill and fill_done still occur.
